// File: rtl/obi_txn_tracker_if.sv
// obi_txn_tracker_if: OBI request/response bus plus tracker status outputs.
// The tracker connects to slave and the driving side connects to master.
interface obi_txn_tracker_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_PND = 2
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_PND + 1);

    logic              req;
    logic              gnt;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic              rvalid;
    logic [CNT_W-1:0]  pnd_cnt;
    logic              full;
    logic              empty;
    logic              rsp_valid;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_we;
    logic [BE_W-1:0]   rsp_be;
    logic              err_unexp_rvalid;
    logic              err_overflow;
    logic              err_req_drop;
    logic              err_req_unstable;
    logic              err_any;

    modport master (
        output req, gnt, addr, we, be, wdata, rvalid,
        input  pnd_cnt, full, empty, rsp_valid, rsp_addr, rsp_we, rsp_be,
               err_unexp_rvalid, err_overflow, err_req_drop, err_req_unstable, err_any
    );
    modport slave (
        input  req, gnt, addr, we, be, wdata, rvalid,
        output pnd_cnt, full, empty, rsp_valid, rsp_addr, rsp_we, rsp_be,
               err_unexp_rvalid, err_overflow, err_req_drop, err_req_unstable, err_any
    );
endinterface

// File: rtl/obi_txn_tracker.sv
// obi_txn_tracker: in-order OBI outstanding-transaction tracker with sticky violation flags.
// Request-stability checking is built only when OBI_TXN_TRACKER_STABILITY_EN is defined.
module obi_txn_tracker #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_PND = 2
) (
    input logic              clock,
    input logic              reset,
    obi_txn_tracker_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_PND + 1);
    localparam int PTR_W = MAX_PND > 1 ? $clog2(MAX_PND) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_PND - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_PND);

    logic [ADDR_W-1:0] addr_q [MAX_PND];
    logic              we_q   [MAX_PND];
    logic [BE_W-1:0]   be_q   [MAX_PND];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              unexp_q, unexp_d, ovf_q, ovf_d;
    logic              accept, retire, push, full, empty;
    logic              err_drop, err_unst;

    always_comb begin
        empty    = cnt_q == '0;
        full     = cnt_q == CNT_MAX;
        accept   = bus.req & bus.gnt;
        retire   = bus.rvalid & !empty;
        push     = accept & (!full | retire);
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(retire);
        wr_ptr_d = push ? (wr_ptr_q == PTR_LAST ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = retire ? (rd_ptr_q == PTR_LAST ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        unexp_d  = unexp_q | (bus.rvalid & empty);
        ovf_d    = ovf_q | (accept & full & !retire);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            unexp_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            unexp_q  <= unexp_d;
            ovf_q    <= ovf_d;
        end
    end

    // Queue payload is deliberately unreset; the pointers and count alone define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_q[wr_ptr_q] <= bus.addr;
            we_q[wr_ptr_q]   <= bus.we;
            be_q[wr_ptr_q]   <= bus.be;
        end
    end

`ifdef OBI_TXN_TRACKER_STABILITY_EN
    logic                          wait_q, drop_q, drop_d, unst_q, unst_d;
    logic [ADDR_W+BE_W+DATA_W:0]   cap_q, fields;

    always_comb begin
        fields = {bus.addr, bus.we, bus.be, bus.wdata};
        drop_d = drop_q | (wait_q & !bus.req);
        unst_d = unst_q | (wait_q & bus.req & (fields != cap_q));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_q <= 1'b0;
            drop_q <= 1'b0;
            unst_q <= 1'b0;
        end else begin
            wait_q <= bus.req & !bus.gnt;
            drop_q <= drop_d;
            unst_q <= unst_d;
        end
    end

    always_ff @(posedge clock) begin
        if (bus.req & !bus.gnt) cap_q <= fields;
    end

    assign err_drop = drop_q;
    assign err_unst = unst_q;
`else
    assign err_drop = 1'b0;
    assign err_unst = 1'b0;
`endif

    assign bus.pnd_cnt          = cnt_q;
    assign bus.full             = full;
    assign bus.empty            = empty;
    assign bus.rsp_valid        = retire;
    assign bus.rsp_addr         = addr_q[rd_ptr_q];
    assign bus.rsp_we           = we_q[rd_ptr_q];
    assign bus.rsp_be           = be_q[rd_ptr_q];
    assign bus.err_unexp_rvalid = unexp_q;
    assign bus.err_overflow     = ovf_q;
    assign bus.err_req_drop     = err_drop;
    assign bus.err_req_unstable = err_unst;
    assign bus.err_any          = unexp_q | ovf_q | err_drop | err_unst;
endmodule

// File: tb/tb_obi_txn_tracker.sv
// tb_obi_txn_tracker: directed scoreboard bench for two tracker instances (MAX_PND 2 and 3).
module tb_obi_txn_tracker;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

`ifdef OBI_TXN_TRACKER_STABILITY_EN
    localparam bit STAB = 1'b1;
`else
    localparam bit STAB = 1'b0;
`endif

    obi_txn_tracker_if #(.ADDR_W(32), .DATA_W(32), .MAX_PND(2)) b2 ();
    obi_txn_tracker_if #(.ADDR_W(32), .DATA_W(32), .MAX_PND(3)) b3 ();

    obi_txn_tracker #(.ADDR_W(32), .DATA_W(32), .MAX_PND(2)) dut2 (.clock(clock), .reset(reset), .bus(b2.slave));
    obi_txn_tracker #(.ADDR_W(32), .DATA_W(32), .MAX_PND(3)) dut3 (.clock(clock), .reset(reset), .bus(b3.slave));

    int checks = 0;
    int failures = 0;
    int mx [2] = '{2, 3};
    int mcnt [2] = '{0, 0};
    bit mun [2] = '{0, 0};
    bit mov [2] = '{0, 0};
    bit mw = 0, mdr = 0, mus = 0;
    logic [31:0] mcap = '0;
    logic [36:0] sb0 [$];
    logic [36:0] sb1 [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        b2.req = 0; b2.gnt = 0; b2.rvalid = 0; b2.addr = '0; b2.we = 0; b2.be = '0; b2.wdata = '0;
        b3.req = 0; b3.gnt = 0; b3.rvalid = 0; b3.addr = '0; b3.we = 0; b3.be = '0; b3.wdata = '0;
    endtask

    task automatic clear_model();
        mcnt = '{0, 0}; mun = '{0, 0}; mov = '{0, 0};
        mw = 0; mdr = 0; mus = 0;
        sb0.delete(); sb1.delete();
    endtask

    // One clock cycle on instance s: drive at negedge, check responses, then registered state.
    task automatic cyc(input int s, input logic rq, input logic gn, input logic [31:0] a, input logic rv);
        logic [36:0] e, rsp;
        logic rvld;
        bit ret, acc;
        @(negedge clock);
        idle();
        if (s == 0) begin
            b2.req = rq; b2.gnt = gn; b2.rvalid = rv; b2.addr = a; b2.we = a[2]; b2.be = a[7:4]; b2.wdata = a;
        end else begin
            b3.req = rq; b3.gnt = gn; b3.rvalid = rv; b3.addr = a; b3.we = a[2]; b3.be = a[7:4]; b3.wdata = a;
        end
        #1;
        rvld = s ? b3.rsp_valid : b2.rsp_valid;
        rsp  = s ? {b3.rsp_be, b3.rsp_we, b3.rsp_addr} : {b2.rsp_be, b2.rsp_we, b2.rsp_addr};
        ret  = rv && mcnt[s] > 0;
        acc  = rq && gn;
        chk("rsp_valid", rvld, ret);
        if (ret) begin
            e = s ? sb1.pop_front() : sb0.pop_front();
            chk("rsp_attr", rsp, e);
        end
        if (rv && !ret) mun[s] = 1;
        if (acc && mcnt[s] == mx[s] && !ret) mov[s] = 1;
        if (acc && (mcnt[s] < mx[s] || ret)) begin
            if (s) sb1.push_back({a[7:4], a[2], a}); else sb0.push_back({a[7:4], a[2], a});
            mcnt[s]++;
        end
        if (ret) mcnt[s]--;
        if (s == 0) begin
            if (STAB && mw && !rq) mdr = 1;
            if (STAB && mw && rq && a != mcap) mus = 1;
            if (rq && !gn) mcap = a;
            mw = rq && !gn;
        end
        @(posedge clock);
        #1;
        chk("pnd_cnt", s ? b3.pnd_cnt : b2.pnd_cnt, mcnt[s]);
        chk("err_unexp", s ? b3.err_unexp_rvalid : b2.err_unexp_rvalid, mun[s]);
        chk("err_ovf", s ? b3.err_overflow : b2.err_overflow, mov[s]);
        chk("err_drop", s ? b3.err_req_drop : b2.err_req_drop, s ? 1'b0 : mdr);
        chk("err_unst", s ? b3.err_req_unstable : b2.err_req_unstable, s ? 1'b0 : mus);
        chk("err_any", s ? b3.err_any : b2.err_any, mun[s] | mov[s] | (s ? 1'b0 : mdr | mus));
    endtask

    task automatic do_reset();
        @(negedge clock);
        idle();
        reset = 1;
        clear_model();
        @(negedge clock);
        reset = 0;
    endtask

    initial begin
        idle();
        repeat (2) @(negedge clock);
        chk("rst_cnt", b2.pnd_cnt, 2'd0);
        chk("rst_empty", b2.empty, 1'b1);
        chk("rst_full", b2.full, 1'b0);
        chk("rst_any", b2.err_any, 1'b0);
        reset = 0;

        // Two accepts then two responses in order.
        cyc(0, 1, 1, 32'h100, 0); chk("t1_cnt1", b2.pnd_cnt, 2'd1);
        cyc(0, 1, 1, 32'h104, 0); chk("t1_cnt2", b2.pnd_cnt, 2'd2); chk("t1_full", b2.full, 1'b1);
        cyc(0, 0, 0, 32'h0, 1);   chk("t1_cnt3", b2.pnd_cnt, 2'd1);
        cyc(0, 0, 0, 32'h0, 1);   chk("t1_cnt4", b2.pnd_cnt, 2'd0); chk("t1_empty", b2.empty, 1'b1);

        // Depth 3: overlapping accept/retire pairs across pointer wrap.
        cyc(1, 1, 1, 32'h0, 0);
        for (int i = 1; i < 6; i++) begin
            cyc(1, 1, 1, 32'(4 * i), 1);
            chk("t2_cnt_le1", b3.pnd_cnt <= 2'd1, 1'b1);
        end
        cyc(1, 0, 0, 32'h0, 1);
        chk("t2_drained", b3.pnd_cnt, 2'd0);

        // Full with simultaneous retire is legal; full without retire overflows.
        cyc(0, 1, 1, 32'h300, 0);
        cyc(0, 1, 1, 32'h304, 0);
        cyc(0, 1, 1, 32'h308, 1); chk("t3_cnt", b2.pnd_cnt, 2'd2); chk("t3_no_ovf", b2.err_overflow, 1'b0);
        cyc(0, 1, 1, 32'h30c, 0); chk("t3_ovf", b2.err_overflow, 1'b1); chk("t3_cnt_hold", b2.pnd_cnt, 2'd2);

        // Asynchronous reset mid-cycle clears state before any clock edge.
        @(negedge clock);
        #2;
        idle();
        reset = 1;
        #1;
        chk("ar_cnt", b2.pnd_cnt, 2'd0);
        chk("ar_empty", b2.empty, 1'b1);
        chk("ar_full", b2.full, 1'b0);
        chk("ar_ovf", b2.err_overflow, 1'b0);
        chk("ar_any", b2.err_any, 1'b0);
        clear_model();
        @(negedge clock);
        reset = 0;

        // Response with nothing outstanding.
        cyc(0, 0, 0, 32'h0, 1); chk("t4_unexp", b2.err_unexp_rvalid, 1'b1); chk("t4_any", b2.err_any, 1'b1);
        cyc(0, 0, 0, 32'h0, 0); chk("t4_sticky", b2.err_any, 1'b1);
        do_reset();

        // Request stability: address change while waiting, then a dropped request.
        cyc(0, 1, 0, 32'h200, 0);
        cyc(0, 1, 0, 32'h204, 0); chk("t5_unst", b2.err_req_unstable, STAB);
        cyc(0, 1, 1, 32'h204, 0);
        cyc(0, 1, 0, 32'h208, 0); chk("t5_no_drop", b2.err_req_drop, 1'b0);
        cyc(0, 0, 0, 32'h0, 0);   chk("t5_drop", b2.err_req_drop, STAB);
        cyc(0, 0, 0, 32'h0, 1);   chk("t5_cnt", b2.pnd_cnt, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/obi_txn_tracker.md
# obi_txn_tracker

Parametrised OBI-style transaction tracker for core memory ports (instruction or data), used in formal wrappers and simulation benches around the core. It counts outstanding granted requests up to a configurable depth and stores per-transaction attributes in an in-order queue, so each response can be matched to its address. It raises sticky protocol-violation flags that a wrapper can assert on or feed to `assume`. This generalises the fixed 2-bit pending counter to arbitrary depth, adds response attribution, and adds request-stability checking.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byte-enable width `BE_W = DATA_W/8`
- `MAX_PND`, 2, maximum outstanding transactions (≥1; need not be a power of two)
- `CNT_W` (local), `$clog2(MAX_PND+1)`, counter width

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req`  in  1  core request
- `gnt`  in  1  memory grant
- `addr`  in  ADDR_W  request address
- `we`  in  1  request write enable
- `be`  in  BE_W  request byte enables
- `wdata`  in  DATA_W  request write data
- `rvalid`  in  1  memory response valid
- `pnd_cnt`  out  CNT_W  outstanding transactions
- `full`  out  1  `pnd_cnt == MAX_PND`
- `empty`  out  1  `pnd_cnt == 0`
- `rsp_valid`  out  1  legal response this cycle
- `rsp_addr`  out  ADDR_W  address of the transaction being answered
- `rsp_we`  out  1  write flag of that transaction
- `rsp_be`  out  BE_W  byte enables of that transaction
- `err_unexp_rvalid`  out  1  sticky: rvalid while empty
- `err_overflow`  out  1  sticky: accept while full with no concurrent retire
- `err_req_drop`  out  1  sticky: req withdrawn before gnt
- `err_req_unstable`  out  1  sticky: addr/we/be/wdata changed before gnt
- `err_any`  out  1  OR of all err_* outputs

## Operation
- accept = `req & gnt`; retire = `rvalid & !empty`.
- Queue: MAX_PND entries of {addr, we, be}; write pointer, read pointer, each wrapping from MAX_PND-1 to 0.
- accept pushes at write pointer unless (full & !retire); retire pops at read pointer.
- Counter: +1 on push only, -1 on pop only, unchanged on both or neither. Never exceeds MAX_PND, never below 0.
- Full with accept and retire in the same cycle: legal; pop and push both occur, count unchanged.
- Empty with rvalid: no pop, `err_unexp_rvalid` set. A same-cycle accept still pushes; a response can never belong to a request granted in the same cycle.
- Full with accept and no retire: push dropped, `err_overflow` set, count held at MAX_PND.
- `rsp_valid = retire`; `rsp_addr/rsp_we/rsp_be` = queue head, combinational, zero latency. These outputs are undefined-but-stable (head entry) when `rsp_valid` = 0.
- Stability tracking: registered `waiting` = `req & !gnt` in the previous cycle, plus captured {addr, we, be, wdata} of that request.
- While `waiting`:
  - `req` = 0 sets `err_req_drop`.
  - `req` = 1 with any field differing from the capture sets `err_req_unstable`.
- Error flags set on the clock edge following the violating cycle. They stay set until reset.

## Timing
- Reset (async assert, applied immediately):
  - `pnd_cnt`=0, `empty`=1, `full`=0
  - pointers=0, `waiting`=0
  - all err_* = 0, `err_any`=0
  - queue contents not reset.
- `rsp_valid`, `rsp_*`, `full`, `empty` are combinational from current state and inputs.
- `pnd_cnt` and err_* are registered, with one-cycle update latency.
- Reset mid-operation discards all outstanding entries. A later rvalid with nothing outstanding flags `err_unexp_rvalid`.

## Configuration
- `OBI_TXN_TRACKER_STABILITY_EN` defined: `waiting` tracking, the capture registers, `err_req_drop` and `err_req_unstable` are built as described.
- Not defined: that logic is omitted, both flags are tied to 0, and `err_any` covers only `err_unexp_rvalid` and `err_overflow`.

## Test plan
- MAX_PND=2: accept at addr 0x100 and then 0x104, then rvalid for two cycles -> `rsp_addr` 0x100 then 0x104; `pnd_cnt` goes 1,2,1,0; no errors.
- MAX_PND=3: six accept/retire pairs offset by one cycle, addrs 0x0..0x14 -> responses return in order across pointer wrap; `pnd_cnt` never exceeds 1.
- Full (2) with accept and rvalid in the same cycle -> `pnd_cnt` stays 2, `rsp_valid`=1, no `err_overflow`; the same accept without rvalid -> `err_overflow`=1 next cycle and `pnd_cnt`=2.
- rvalid after reset with nothing outstanding -> `rsp_valid`=0, `err_unexp_rvalid`=1 next edge, `err_any`=1 until reset.
- Macro defined: req=1 addr 0x200 gnt=0, next cycle addr 0x204 -> `err_req_unstable`=1; req dropped before gnt -> `err_req_drop`=1. Macro undefined: same stimulus -> both flags stay 0.
- Reset asserted asynchronously with `pnd_cnt`=2 -> `pnd_cnt`=0 and all flags 0 immediately, before the next clock edge.
